// File: rtl/comma_word_aligner_if.sv
// comma_word_aligner_if: raw deserializer word in, aligned symbol and link status out
interface comma_word_aligner_if;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic data_valid;
  logic comma_det;
  logic locked;
  logic [3:0] offset;
  logic [15:0] realign_cnt;
  modport master (output data_in, input data_out, data_valid, comma_det, locked, offset, realign_cnt);
  modport slave (input data_in, output data_out, data_valid, comma_det, locked, offset, realign_cnt);
endinterface

// File: rtl/comma_word_aligner.sv
// comma_word_aligner: K28.5 comma search, hysteretic lock and word alignment of the raw deserializer stream
module comma_word_aligner #(
  parameter logic [9:0] COMMA_N = 10'b0011111010,
  parameter logic [9:0] COMMA_P = 10'b1100000101,
  parameter int LOCK_CNT = 4,
  parameter int UNLOCK_CNT = 4,
  parameter int VERIFY_TIMEOUT = 1024,
  parameter logic [15:0] REALIGN_MAX = 16'hFFFF
) (
  input logic clk,
  input logic rst,
  comma_word_aligner_if.slave bus
);
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam int TW = $clog2(VERIFY_TIMEOUT) + 1;
  logic [1:0] state;
  logic [9:0] cur_q, prev_q, match;
  logic [9:0] cand [10];
  logic [3:0] off_q, low_k, good_cnt, bad_cnt;
  logic [TW-1:0] timer;
  logic [19:0] w;
  assign w = {prev_q, cur_q};
  for (genvar i = 0; i < 10; i++) begin : g_cand
    assign cand[i] = w[19-i -: 10];
    assign match[i] = cand[i] == COMMA_N || cand[i] == COMMA_P;
  end
  assign bus.locked = state == LOCKED;
  assign bus.offset = off_q;
  // lowest matching offset wins when several bit positions hold a comma
  always_comb begin
    low_k = 4'd0;
    for (int j = 9; j >= 0; j--) if (match[j]) low_k = 4'(j);
  end
  // two-word window pipeline and the aligned output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      prev_q <= '0;
      bus.data_out <= '0;
      bus.comma_det <= 1'b0;
      bus.data_valid <= 1'b0;
    end else begin
      cur_q <= bus.data_in;
      prev_q <= cur_q;
      bus.data_out <= cand[off_q];
      bus.comma_det <= match[off_q];
      bus.data_valid <= state == LOCKED;
    end
  end
  // hunt / verify / locked alignment state machine with hysteresis
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      off_q <= '0;
      good_cnt <= '0;
      bad_cnt <= '0;
      timer <= '0;
      bus.realign_cnt <= '0;
    end else begin
      case (state)
        HUNT: if (|match) begin
          state <= LOCK_CNT == 1 ? LOCKED : VERIFY;
          off_q <= low_k;
          good_cnt <= 4'd1;
          bad_cnt <= '0;
          timer <= '0;
        end
        VERIFY: if (match[off_q]) begin
          good_cnt <= good_cnt + 4'd1;
          timer <= '0;
          if (good_cnt + 4'd1 == 4'(LOCK_CNT)) state <= LOCKED;
        end else if (|match) begin
          off_q <= low_k;
          good_cnt <= 4'd1;
          timer <= '0;
        end else if (timer == TW'(VERIFY_TIMEOUT - 1)) begin
          state <= HUNT;
          timer <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
        LOCKED: if (match[off_q]) begin
          bad_cnt <= '0;
        end else if (|match) begin
          if (bad_cnt + 4'd1 == 4'(UNLOCK_CNT)) begin
            state <= HUNT;
            bad_cnt <= '0;
            bus.realign_cnt <= bus.realign_cnt == REALIGN_MAX ? bus.realign_cnt : bus.realign_cnt + 16'd1;
          end else begin
            bad_cnt <= bad_cnt + 4'd1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_comma_word_aligner.sv
// tb_comma_word_aligner: self-checking bench for comma_word_aligner
module tb_comma_word_aligner;
  localparam logic [9:0] CN = 10'b0011111010;
  localparam logic [9:0] CP = 10'b1100000101;
  localparam int LOCKN = 4;
  localparam int UNLOCKN = 4;
  localparam int VT = 1024;
  logic clk = 1'b0;
  logic rst = 1'b0;
  comma_word_aligner_if bus();
  comma_word_aligner_if bus2();
  comma_word_aligner dut (.clk(clk), .rst(rst), .bus(bus));
  comma_word_aligner #(.LOCK_CNT(1), .UNLOCK_CNT(1), .REALIGN_MAX(16'd20)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  typedef struct {
    int shift;
    bit alt;
    logic [3:0] off;
  } row_t;
  row_t rows [4];
  int n_cmp = 0;
  int n_bad = 0;
  bit bq [$];
  bit to2 = 0;
  bit chk_seq = 0;
  bit seen_n, seen_p, ever_locked;
  int last_dec = -1;
  int dctr = 0;
  int m_mode, m_off, m_good, m_bad, m_quiet, m_rc;
  logic [9:0] h0, h1, e_dout;
  bit e_cdet, e_dv;
  function automatic bit is_comma(input logic [9:0] v);
    return v == CN || v == CP;
  endfunction
  function automatic logic [9:0] enc(input int n);
    logic [4:0] v;
    logic [9:0] s;
    v = 5'(n);
    for (int i = 0; i < 5; i++) begin
      s[2*i+1] = v[i];
      s[2*i] = ~v[i];
    end
    return s;
  endfunction
  function automatic logic [32:0] got();
    return {bus.data_out, bus.data_valid, bus.comma_det, bus.locked, bus.offset, bus.realign_cnt};
  endfunction
  function automatic logic [32:0] expv();
    return {e_dout, e_dv, e_cdet, m_mode == 2, 4'(m_off), 16'(m_rc)};
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask
  task automatic model_step(input logic [9:0] x, input bit r);
    logic [19:0] win;
    int first;
    bit here;
    if (r) begin
      h0 = '0; h1 = '0; e_dout = '0; e_cdet = 0; e_dv = 0;
      m_mode = 0; m_off = 0; m_good = 0; m_bad = 0; m_quiet = 0; m_rc = 0;
      return;
    end
    win = {h1, h0};
    first = -1;
    for (int k = 9; k >= 0; k--) if (is_comma(10'(win >> (10 - k)))) first = k;
    e_dout = 10'(win >> (10 - m_off));
    here = is_comma(e_dout);
    e_cdet = here;
    e_dv = m_mode == 2;
    if (m_mode == 0) begin
      if (first >= 0) begin
        m_off = first; m_good = 1; m_quiet = 0; m_bad = 0;
        m_mode = LOCKN == 1 ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if (here) begin
        m_good++; m_quiet = 0;
        if (m_good == LOCKN) m_mode = 2;
      end else if (first >= 0) begin
        m_off = first; m_good = 1; m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == VT) begin m_mode = 0; m_quiet = 0; end
      end
    end else if (!here && first >= 0) begin
      m_bad++;
      if (m_bad == UNLOCKN) begin
        m_mode = 0; m_bad = 0;
        if (m_rc < 65535) m_rc++;
      end
    end else if (here) begin
      m_bad = 0;
    end
    h1 = h0;
    h0 = x;
  endtask
  task automatic tick(input logic [9:0] wd);
    logic [4:0] dec;
    bus.data_in = to2 ? 10'd0 : wd;
    bus2.data_in = to2 ? wd : 10'd0;
    @(posedge clk);
    model_step(bus.data_in, rst);
    @(negedge clk);
    check("cycle", 64'(got()), 64'(expv()));
    if (bus.comma_det && bus.data_out == CN) seen_n = 1;
    if (bus.comma_det && bus.data_out == CP) seen_p = 1;
    if (bus.locked) ever_locked = 1;
    if (chk_seq && bus.data_valid && !bus.comma_det) begin
      dec = {bus.data_out[9], bus.data_out[7], bus.data_out[5], bus.data_out[3], bus.data_out[1]};
      if (last_dec >= 0) check("seq", 64'(dec), 64'((last_dec + 1) % 32));
      last_dec = int'(dec);
    end
  endtask
  task automatic drain();
    logic [9:0] wd;
    while (bq.size() >= 10) begin
      for (int i = 9; i >= 0; i--) wd[i] = bq.pop_front();
      tick(wd);
    end
  endtask
  task automatic push_sym(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) bq.push_back(v[i]);
    drain();
  endtask
  task automatic push_slip(input int n);
    for (int i = 0; i < n; i++) bq.push_back(i % 2 == 0);
    drain();
  endtask
  task automatic pair(input bit pol);
    push_sym(pol ? CP : CN);
    push_sym(enc(dctr));
    dctr++;
  endtask
  task automatic data_syms(input int n);
    for (int i = 0; i < n; i++) begin
      push_sym(enc(dctr));
      dctr++;
    end
  endtask
  task automatic do_reset();
    bq.delete();
    rst = 1'b1;
    tick(10'd0);
    check("rst_out", 64'(got()), 64'(0));
    check("rst_out2", 64'({bus2.data_out, bus2.data_valid, bus2.comma_det, bus2.locked, bus2.offset, bus2.realign_cnt}), 64'(0));
    rst = 1'b0;
    ever_locked = 0;
    seen_n = 0;
    seen_p = 0;
    last_dec = -1;
    dctr = 0;
  endtask
  initial begin
    rows[0] = '{shift: 3, alt: 1'b0, off: 4'd3};
    rows[1] = '{shift: 0, alt: 1'b1, off: 4'd0};
    rows[2] = '{shift: 1, alt: 1'b1, off: 4'd1};
    rows[3] = '{shift: 9, alt: 1'b1, off: 4'd9};
    bus.data_in = '0;
    bus2.data_in = '0;
    foreach (rows[r]) begin
      do_reset();
      chk_seq = 1;
      push_slip(rows[r].shift);
      for (int i = 0; i < 12; i++) begin
        pair(rows[r].alt && (i % 2 == 1));
        if (i == 3) check("pre_lock", 64'(bus.locked), 64'(0));
        if (i == 4) begin
          check("lock", 64'(bus.locked), 64'(1));
          check("lock_off", 64'(bus.offset), 64'(rows[r].off));
        end
      end
      check("polarity", 64'({seen_n, seen_p}), rows[r].alt ? 64'(2'b11) : 64'(2'b10));
      chk_seq = 0;
    end
    do_reset();
    push_slip(3);
    for (int i = 0; i < 6; i++) pair(0);
    check("slip_lock", 64'({bus.locked, bus.offset}), 64'({1'b1, 4'd3}));
    push_slip(4);
    for (int i = 0; i < 3; i++) pair(0);
    push_slip(6);
    for (int i = 0; i < 3; i++) pair(0);
    check("slip3_hold", 64'({bus.locked, bus.offset, bus.realign_cnt}), 64'({1'b1, 4'd3, 16'd0}));
    push_slip(4);
    for (int i = 0; i < 4; i++) pair(0);
    check("slip4_pre", 64'({bus.locked, bus.realign_cnt}), 64'({1'b1, 16'd0}));
    pair(0);
    check("slip4_drop", 64'({bus.locked, bus.realign_cnt}), 64'({1'b0, 16'd1}));
    for (int i = 0; i < 3; i++) pair(0);
    check("relock_pre", 64'(bus.locked), 64'(0));
    pair(0);
    check("relock", 64'({bus.locked, bus.offset, bus.realign_cnt}), 64'({1'b1, 4'd7, 16'd1}));
    do_reset();
    push_slip(2);
    pair(0);
    pair(0);
    data_syms(1023);
    for (int i = 0; i < 3; i++) pair(0);
    check("timeout", 64'({bus.locked, ever_locked}), 64'(0));
    do_reset();
    push_slip(2);
    pair(0);
    pair(0);
    data_syms(1022);
    for (int i = 0; i < 3; i++) pair(0);
    check("no_timeout", 64'({bus.locked, bus.offset}), 64'({1'b1, 4'd2}));
    data_syms(1100);
    check("quiet_lock", 64'(bus.locked), 64'(1));
    do_reset();
    push_slip(5);
    for (int i = 0; i < 5; i++) pair(1);
    check("post_rst", 64'({bus.locked, bus.offset}), 64'({1'b1, 4'd5}));
    do_reset();
    for (int i = 0; i < 700; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) push_sym(r == 0 ? CP : CN);
      else if (r == 3) push_slip($urandom_range(1, 9));
      else if (r == 9 && $urandom_range(0, 60) == 0) do_reset();
      else push_sym(10'($urandom));
    end
    do_reset();
    to2 = 1;
    for (int n = 1; n <= 60; n++) begin
      push_sym(CN);
      push_slip(5);
      if (n == 20) check("sat_mid", 64'(bus2.realign_cnt), 64'(9));
      if (n == 42) check("sat_edge", 64'(bus2.realign_cnt), 64'(20));
      if (n == 60) check("sat_hold", 64'(bus2.realign_cnt), 64'(20));
    end
    to2 = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
